// File: rtl/fpu_dispatch_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fpu_dispatch_if                                         |
// | Purpose  : core request, FPU handshake and write-back signals for  |
// |            the FP dispatch stage.                                  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface fpu_dispatch_if #(
  parameter int LEN_WORD  = 32,
  parameter int LEN_REG   = 5,
  parameter int LEN_FUNC3 = 3,
  parameter int LEN_FUNC7 = 7
);
  // core request side
  logic                 req_valid;
  logic                 req_ready;
  logic [LEN_FUNC3-1:0] req_func3;
  logic [LEN_FUNC7-1:0] req_func7;
  logic [LEN_WORD-1:0]  req_rs1;
  logic [LEN_WORD-1:0]  req_rs2;
  logic [LEN_REG-1:0]   req_rd_idx;
  logic                 req_to_int;
  // FPU side
  logic                 fpu_order;
  logic                 fpu_accepted;
  logic                 fpu_done;
  logic [LEN_FUNC3-1:0] fpu_func3;
  logic [LEN_FUNC7-1:0] fpu_func7;
  logic [LEN_WORD-1:0]  fpu_rs1;
  logic [LEN_WORD-1:0]  fpu_rs2;
  logic [LEN_WORD-1:0]  fpu_rd;
  // write-back side
  logic                 wb_valid;
  logic                 wb_ready;
  logic [LEN_REG-1:0]   wb_idx;
  logic                 wb_to_int;
  logic [LEN_WORD-1:0]  wb_data;
  // status
  logic                 busy;
  logic                 timeout_err;

  // environment view: core, FPU and register files
  modport master (
    output req_valid, req_func3, req_func7, req_rs1, req_rs2, req_rd_idx, req_to_int,
    input  req_ready,
    input  fpu_order, fpu_func3, fpu_func7, fpu_rs1, fpu_rs2,
    output fpu_accepted, fpu_done, fpu_rd,
    input  wb_valid, wb_idx, wb_to_int, wb_data,
    output wb_ready,
    input  busy, timeout_err
  );

  // dispatch stage view
  modport slave (
    input  req_valid, req_func3, req_func7, req_rs1, req_rs2, req_rd_idx, req_to_int,
    output req_ready,
    output fpu_order, fpu_func3, fpu_func7, fpu_rs1, fpu_rs2,
    input  fpu_accepted, fpu_done, fpu_rd,
    output wb_valid, wb_idx, wb_to_int, wb_data,
    input  wb_ready,
    output busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/fpu_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : fpu_dispatch                                            |
// | Purpose  : single-outstanding FP issue stage: latches operands,    |
// |            drives the FPU order/accepted/done handshake, returns   |
// |            the result as a write-back, with a lost-done watchdog.  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module fpu_dispatch #(
  parameter int LEN_WORD  = 32,
  parameter int LEN_REG   = 5,
  parameter int LEN_FUNC3 = 3,
  parameter int LEN_FUNC7 = 7,
  parameter int TIMEOUT   = 1023
) (
  input  wire logic      clk,
  input  wire logic      rstn,
  fpu_dispatch_if.slave  bus
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);
  localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2,
    S_WB    = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_cnt;
  logic                 r_order;
  logic                 r_wb_valid;
  logic [LEN_WORD-1:0]  r_wb_data;
  logic                 r_busy;
  logic                 r_timeout_err;
  logic [LEN_FUNC3-1:0] r_func3;
  logic [LEN_FUNC7-1:0] r_func7;
  logic [LEN_WORD-1:0]  r_rs1;
  logic [LEN_WORD-1:0]  r_rs2;
  logic [LEN_REG-1:0]   r_rd_idx;
  logic                 r_to_int;

  logic w_take;
  logic w_expired;

  // Ready in IDLE, or in WB the cycle the write-back drains (bypass to ISSUE).
  assign bus.req_ready = rstn & ((r_state == S_IDLE) | ((r_state == S_WB) & bus.wb_ready));
  assign w_take        = bus.req_valid & bus.req_ready;
  assign w_expired     = (r_cnt == c_timeout);

  assign bus.fpu_order   = r_order;
  assign bus.fpu_func3   = r_func3;
  assign bus.fpu_func7   = r_func7;
  assign bus.fpu_rs1     = r_rs1;
  assign bus.fpu_rs2     = r_rs2;
  assign bus.wb_valid    = r_wb_valid;
  assign bus.wb_data     = r_wb_data;
  // Destination fields only change on a new handshake, which cannot happen
  // until the pending write-back is consumed, so they double as wb_* outputs.
  assign bus.wb_idx      = r_rd_idx;
  assign bus.wb_to_int   = r_to_int;
  assign bus.busy        = r_busy;
  assign bus.timeout_err = r_timeout_err;

  // Operand/destination latch, loaded on every request handshake.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_func3  <= '0;
      r_func7  <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd_idx <= '0;
      r_to_int <= 1'b0;
    end else if (w_take) begin
      r_func3  <= bus.req_func3;
      r_func7  <= bus.req_func7;
      r_rs1    <= bus.req_rs1;
      r_rs2    <= bus.req_rs2;
      r_rd_idx <= bus.req_rd_idx;
      r_to_int <= bus.req_to_int;
    end
  end

  // Control FSM with watchdog; all handshake outputs registered here.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_order       <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_data     <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_state <= S_ISSUE;
            r_order <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          if (bus.fpu_accepted && bus.fpu_done) begin
            r_wb_data  <= bus.fpu_rd;
            r_state    <= S_WB;
            r_order    <= 1'b0;
            r_wb_valid <= 1'b1;
          end else if (w_expired) begin
            // A done without accept is not a completion, so it cannot win here.
            r_wb_data     <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_WB;
            r_order       <= 1'b0;
            r_wb_valid    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
            if (bus.fpu_accepted) begin
              r_state <= S_EXEC;
              r_order <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          if (bus.fpu_done) begin
            r_wb_data  <= bus.fpu_rd;
            r_state    <= S_WB;
            r_wb_valid <= 1'b1;
          end else if (w_expired) begin
            r_wb_data     <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_WB;
            r_wb_valid    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        default: begin  // S_WB: hold result until consumed
          if (bus.wb_ready) begin
            r_wb_valid <= 1'b0;
            if (bus.req_valid) begin
              r_state <= S_ISSUE;
              r_order <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_fpu_dispatch                                         |
// | Purpose  : self-checking bench for fpu_dispatch (TIMEOUT = 15):    |
// |            vector table plus bypass and reset sequences, with a    |
// |            write-back scoreboard.                                  |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_fpu_dispatch;

  localparam int TMO = 15;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  idx;
    logic        to_int;
    int          a;      // order cycles before FPU accepts
    int          k;      // cycles from accept to done
    logic        never;  // FPU never sends done
    logic [31:0] rd;
    int          stall;  // cycles of wb_ready low
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        to_int;
    logic        terr;
  } exp_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_applied = 0;
  int   n_miss = 0;
  logic exp_terr = 1'b0;
  exp_t sb[$];
  exp_t last_exp;
  vec_t vecs[8];

  fpu_dispatch_if #(.LEN_WORD(32), .LEN_REG(5), .LEN_FUNC3(3), .LEN_FUNC7(7)) bus ();

  fpu_dispatch #(
    .LEN_WORD(32), .LEN_REG(5), .LEN_FUNC3(3), .LEN_FUNC7(7), .TIMEOUT(TMO)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // step to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    bus.req_valid  = 1'b1;
    bus.req_func3  = v.f3;
    bus.req_func7  = v.f7;
    bus.req_rs1    = v.rs1;
    bus.req_rs2    = v.rs2;
    bus.req_rd_idx = v.idx;
    bus.req_to_int = v.to_int;
  endtask

  task automatic push_exp(input vec_t v);
    exp_t e;
    exp_terr   = exp_terr | v.never;
    e.data     = v.never ? 32'h0 : v.rd;
    e.idx      = v.idx;
    e.to_int   = v.to_int;
    e.terr     = exp_terr;
    sb.push_back(e);
  endtask

  // handshake cycle T from IDLE; leaves the bench in cycle T+1
  task automatic issue_req(input vec_t v, input bit push);
    drive_req(v);
    #1;
    check("req_ready_idle", bus.req_ready, 1);
    if (push) push_exp(v);
    tick();
    bus.req_valid = 1'b0;
    check("order_after_req", bus.fpu_order, 1);
  endtask

  // FPU model from cycle T+1 until wb_valid (bounded)
  task automatic fpu_phase(input vec_t v);
    int iters = 0, waited = 0, kk = 0, order_cyc = 0, unstable = 0;
    bit acc_seen = 1'b0;
    while (!bus.wb_valid && iters < 64) begin
      if (bus.fpu_order) order_cyc++;
      if (bus.fpu_rs1 !== v.rs1 || bus.fpu_rs2 !== v.rs2 ||
          bus.fpu_func3 !== v.f3 || bus.fpu_func7 !== v.f7) unstable++;
      bus.fpu_accepted = 1'b0;
      bus.fpu_done     = 1'b0;
      bus.fpu_rd       = $urandom;
      if (!acc_seen) begin
        if (bus.fpu_order && waited == v.a) begin
          bus.fpu_accepted = 1'b1;
          acc_seen = 1'b1;
          if (!v.never && v.k == 0) begin
            bus.fpu_done = 1'b1;
            bus.fpu_rd   = v.rd;
          end
        end else begin
          waited++;
        end
      end else begin
        kk++;
        if (!v.never && kk == v.k) begin
          bus.fpu_done = 1'b1;
          bus.fpu_rd   = v.rd;
        end
      end
      tick();
      iters++;
    end
    bus.fpu_accepted = 1'b0;
    bus.fpu_done     = 1'b0;
    bus.fpu_rd       = $urandom;
    check("wb_latency", iters, v.never ? TMO + 1 : 1 + v.a + v.k);
    check("operand_stable", unstable, 0);
    if (!v.never) check("order_cycles", order_cyc, v.a + 1);
  endtask

  // scoreboard pop at the write-back
  task automatic wb_observe();
    check("wb_valid", bus.wb_valid, 1);
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
    end else begin
      last_exp = sb.pop_front();
      check("wb_data", bus.wb_data, last_exp.data);
      check("wb_idx", bus.wb_idx, last_exp.idx);
      check("wb_to_int", bus.wb_to_int, last_exp.to_int);
      check("timeout_err", bus.timeout_err, last_exp.terr);
    end
  endtask

  // hold wb_ready low for stall cycles, then consume and return to IDLE
  task automatic finish_wb(input int stall);
    for (int i = 0; i < stall; i++) begin
      bus.wb_ready = 1'b0;
      bus.fpu_rd   = $urandom;
      #1;
      check("stall_wb_valid", bus.wb_valid, 1);
      check("stall_wb_data", bus.wb_data, last_exp.data);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    check("req_ready_wb", bus.req_ready, 1);
    tick();
    bus.wb_ready = 1'b0;
    check("wb_drop", bus.wb_valid, 0);
    check("idle_busy", bus.busy, 0);
  endtask

  initial begin
    vec_t va, vb, vr;

    vecs[0] = '{32'h3F800000, 32'h00000000, 3'd0, 7'h00, 5'd7,  1'b0, 0,  0,  1'b0, 32'h3F800000, 0};
    vecs[1] = '{32'h40490FDB, 32'h3F800000, 3'd0, 7'h08, 5'd3,  1'b0, 3,  10, 1'b0, 32'h40490FDB, 0};
    vecs[2] = '{32'h41200000, 32'h40A00000, 3'd2, 7'h50, 5'd10, 1'b1, 1,  2,  1'b0, 32'h00000001, 2};
    vecs[3] = '{32'hC0000000, 32'h3F000000, 3'd7, 7'h10, 5'd31, 1'b0, 0,  15, 1'b0, 32'h12345678, 0};
    vecs[4] = '{32'h7F7FFFFF, 32'h00800000, 3'd1, 7'h2C, 5'd0,  1'b0, 2,  12, 1'b0, 32'hABCD0123, 1};
    vecs[5] = '{32'h11111111, 32'h22222222, 3'd3, 7'h60, 5'd4,  1'b1, 0,  0,  1'b1, 32'h55555555, 0};
    vecs[6] = '{32'h33333333, 32'h44444444, 3'd4, 7'h04, 5'd9,  1'b0, 0,  1,  1'b0, 32'hDEADBEEF, 0};
    vecs[7] = '{32'h66666666, 32'h77777777, 3'd5, 7'h14, 5'd12, 1'b0, 99, 0,  1'b1, 32'h00000000, 0};

    bus.req_valid = 1'b0; bus.req_func3 = '0; bus.req_func7 = '0;
    bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_rd_idx = '0; bus.req_to_int = 1'b0;
    bus.fpu_accepted = 1'b0; bus.fpu_done = 1'b0; bus.fpu_rd = '0; bus.wb_ready = 1'b0;

    // reset state
    rstn = 1'b0;
    tick(); tick();
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_order", bus.fpu_order, 0);
    check("rst_wb_valid", bus.wb_valid, 0);
    check("rst_wb_data", bus.wb_data, 0);
    check("rst_wb_idx", bus.wb_idx, 0);
    check("rst_fpu_rs1", bus.fpu_rs1, 0);
    check("rst_terr", bus.timeout_err, 0);
    rstn = 1'b1;
    #1;
    check("rst_release_ready", bus.req_ready, 1);
    tick();

    // table-driven operations
    for (int i = 0; i < 8; i++) begin
      issue_req(vecs[i], 1'b1);
      fpu_phase(vecs[i]);
      wb_observe();
      finish_wb(vecs[i].stall);
    end

    // back-pressure with a new request waiting, then WB->ISSUE bypass
    va = '{32'h3FC00000, 32'h40000000, 3'd0, 7'h00, 5'd5, 1'b0, 0, 1, 1'b0, 32'h40400000, 0};
    vb = '{32'hBF800000, 32'h3E800000, 3'd1, 7'h04, 5'd6, 1'b1, 1, 0, 1'b0, 32'hCAFEF00D, 0};
    issue_req(va, 1'b1);
    fpu_phase(va);
    wb_observe();
    drive_req(vb);
    for (int i = 0; i < 5; i++) begin
      bus.wb_ready = 1'b0;
      bus.fpu_rd   = $urandom;
      #1;
      check("bp_wb_valid", bus.wb_valid, 1);
      check("bp_wb_data", bus.wb_data, last_exp.data);
      check("bp_req_ready", bus.req_ready, 0);
      tick();
    end
    bus.wb_ready = 1'b1;
    #1;
    check("bypass_ready", bus.req_ready, 1);
    push_exp(vb);
    tick();
    bus.wb_ready  = 1'b0;
    bus.req_valid = 1'b0;
    check("bypass_order", bus.fpu_order, 1);
    check("bypass_rs1", bus.fpu_rs1, vb.rs1);
    check("bypass_wb_drop", bus.wb_valid, 0);
    fpu_phase(vb);
    wb_observe();
    finish_wb(0);

    // reset while in EXEC; in-flight op is discarded
    vr = '{32'h01020304, 32'h05060708, 3'd6, 7'h7F, 5'd17, 1'b0, 0, 0, 1'b1, 32'h0, 0};
    issue_req(vr, 1'b0);
    bus.fpu_accepted = 1'b1;
    tick();
    bus.fpu_accepted = 1'b0;
    tick(); tick();
    check("exec_busy", bus.busy, 1);
    rstn = 1'b0;
    tick();
    exp_terr = 1'b0;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_wb_valid", bus.wb_valid, 0);
    check("mid_rst_order", bus.fpu_order, 0);
    check("mid_rst_terr", bus.timeout_err, exp_terr);
    check("mid_rst_rs1", bus.fpu_rs1, 0);
    check("mid_rst_ready_low", bus.req_ready, 0);
    rstn = 1'b1;
    #1;
    check("mid_rst_ready", bus.req_ready, 1);
    bus.fpu_done = 1'b1;
    bus.fpu_rd   = 32'hBADBAD00;
    tick();
    bus.fpu_done = 1'b0;
    check("late_done_wb", bus.wb_valid, 0);
    check("late_done_busy", bus.busy, 0);
    tick();
    check("late_done_wb2", bus.wb_valid, 0);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

  // global run bound
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

endmodule
`default_nettype wire

// File: doc/fpu_dispatch.md
# fpu_dispatch

Upstream issue stage for the floating-point unit: accepts one decoded FP instruction from the core, holds its operands stable, drives the FPU `order`/`accepted`/`done` handshake, and delivers the result as a write-back request to either register file. Only one instruction is outstanding at a time. A cycle watchdog stops a lost `done` from hanging the core.

## Interface
- `LEN_WORD`, 32, operand/result width
- `LEN_REG`, 5, register index width
- `TIMEOUT`, 1023, max cycles in ISSUE+EXEC before forced completion; counter width is clog2(TIMEOUT+1)

- `clk`  in  1  clock
- `rstn`  in  1  reset; one clock, reset is synchronous and active-low
- `req_valid`  in  1  decoded FP instruction present
- `req_ready`  out  1  instruction taken this cycle when high together with `req_valid`
- `req_func3`  in  `LEN_FUNC3`  instruction func3
- `req_func7`  in  `LEN_FUNC7`  instruction func7
- `req_rs1`, `req_rs2`  in  `LEN_WORD`  operands
- `req_rd_idx`  in  `LEN_REG`  destination register index
- `req_to_int`  in  1  result goes to the integer file (compare, ftoi, fmvi)
- `fpu_order`  out  1  order to FPU
- `fpu_accepted`  in  1  FPU took the order
- `fpu_done`  in  1  FPU result valid this cycle
- `fpu_func3`, `fpu_func7`, `fpu_rs1`, `fpu_rs2`  out  as req  latched fields
- `fpu_rd`  in  `LEN_WORD`  FPU result
- `wb_valid`  out  1  write-back request
- `wb_ready`  in  1  write-back consumed
- `wb_idx`  out  `LEN_REG`  destination index
- `wb_to_int`  out  1  destination file select
- `wb_data`  out  `LEN_WORD`  result
- `busy`  out  1  state is not IDLE
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, EXEC, WB.
- `req_ready` = (IDLE) | (WB & `wb_ready`). It is forced to 0 while `rstn`=0.
- On a request handshake, latch func3, func7, rs1, rs2, rd_idx and to_int, then go to ISSUE. The `fpu_*` operand outputs are driven only from these latches and stay stable from ISSUE through WB.
- ISSUE: `fpu_order`=1.
  - `fpu_accepted` & `fpu_done` in the same cycle: capture `fpu_rd` and go to WB.
  - `fpu_accepted` alone: go to EXEC.
  - Neither: stay in ISSUE, keep ordering.
- EXEC: `fpu_order`=0. On `fpu_done`, capture `fpu_rd` and go to WB.
- Watchdog:
  - The counter clears on entry to ISSUE and increments every ISSUE/EXEC cycle.
  - If the count equals TIMEOUT and `fpu_done` is low, load `wb_data`=0, set `timeout_err`, and go to WB.
  - If `fpu_done` arrives in the same cycle, `fpu_done` wins and no error is raised.
- WB: `wb_valid`=1. `wb_data`, `wb_idx` and `wb_to_int` are held until `wb_ready`.
  - `wb_ready` without `req_valid`: go to IDLE.
  - `wb_ready` & `req_valid`: latch the new request and go directly to ISSUE.
- `fpu_done` while in IDLE or WB (a spurious pulse) is ignored.
- `timeout_err` is cleared only by reset.

## Timing
- Reset values: state IDLE, counter 0, `fpu_order`=0, `wb_valid`=0, `wb_data`=0, `wb_idx`=0, `wb_to_int`=0, all `fpu_*` operand outputs 0, `busy`=0, `timeout_err`=0. `req_ready`=1 from the first cycle with `rstn`=1.
- Reset while in any state returns to IDLE on the next edge. The in-flight instruction is discarded and no write-back is issued.
- Let handshake cycle be T, and let the FPU assert done k cycles after accepting (k=0 means the same cycle). Then `fpu_order` is high in T+1, and `wb_valid` rises at T+2+k+a, where a is the number of cycles the FPU delays accept.
- Peak throughput is one single-cycle instruction per 2 cycles, using the WB→ISSUE bypass.
- All outputs come directly from registers, except `req_ready`, which also depends on `wb_ready`.

## Test plan
- Single-cycle op: request rs1=0x3F800000, idx=7, to_int=0 at T. The FPU model returns accepted=done=1 with rd=0x3F800000 at T+1. Required: `wb_valid` at T+2 with `wb_data`=0x3F800000, `wb_idx`=7.
- Delayed accept: FPU holds accepted low for 3 cycles, then done 10 cycles after accept with rd=0x40490FDB. Required: `fpu_order` high for exactly 4 cycles, `fpu_rs1`/`fpu_rs2` stable throughout, `wb_data`=0x40490FDB.
- Back-pressure: `wb_ready` low for 5 cycles. Required: `wb_valid`/`wb_data` stable and `req_ready`=0 throughout. Then assert `wb_ready` and `req_valid` together. Required: the new request is latched and `fpu_order`=1 the next cycle.
- Timeout, with TIMEOUT=15: FPU accepts and never sends done. Required: forced completion at count 15, `wb_valid` with `wb_data`=0, and `timeout_err`=1 staying set across later normal ops.
- Race, with TIMEOUT=15: `fpu_done` with rd=0x12345678 arrives in the cycle the count reaches 15. Required: `wb_data`=0x12345678 and `timeout_err`=0.
- Reset during EXEC: `rstn`=0 for one cycle. Required: the next cycle shows `busy`=0, `wb_valid`=0, `fpu_order`=0, and `req_ready`=1 once `rstn`=1; a late `fpu_done` produces no write-back.
